regex_pc_buffer: RTL and testbench
==================================

Name: regex_pc_buffer

Overview:
- Thread-list FIFO holding (cc_id, pc) pairs.
- Written by regex_cpu's output_pc port; read by regex_cpu's input_pc port, or by the dispatcher in front of it.
- Decouples instruction completion from instruction issue so that every spawned pc is executed in order.
- Both sides use valid/ready handshakes. A transfer occurs on any rising clk edge where valid and ready are both 1.

Parameters:
- PC_WIDTH, 9, width of a program counter.
- CC_ID_BITS, 2, width of the character-context id.
- DEPTH_BITS, 4, log2 of buffer depth (default depth 16 entries).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all entries; takes priority over push and pop in the same cycle.
- in_pc_valid  in  1  upstream offers an entry.
- in_cc_id  in  CC_ID_BITS  cc_id of the offered entry.
- in_pc  in  PC_WIDTH  pc of the offered entry.
- in_pc_ready  out  1  buffer can accept an entry; equals !full && !flush.
- out_pc_valid  out  1  head entry is valid; equals !empty.
- out_cc_id  out  CC_ID_BITS  cc_id of the head entry.
- out_pc  out  PC_WIDTH  pc of the head entry.
- out_pc_ready  in  1  downstream consumes the head entry.
- count  out  DEPTH_BITS+1  number of stored entries, 0..2**DEPTH_BITS.
- empty  out  1  count == 0.
- full  out  1  count == 2**DEPTH_BITS.

Behaviour:
- Reset (rst = 0, asynchronous):
  - Pointers and count go to 0.
  - Outputs: out_pc_valid = 0, empty = 1, full = 0, count = 0, in_pc_ready = 1 once rst is released.
  - out_pc and out_cc_id reset to 0.
  - Entry storage is not reset.
- Reset asserted mid-operation discards all entries immediately, with no partial transfer.
- Storage:
  - Circular array of 2**DEPTH_BITS entries, each {cc_id, pc}.
  - Read and write pointers are DEPTH_BITS wide and wrap modulo depth.
  - count is tracked separately.
- Push: in_pc_valid && in_pc_ready. The entry is written at the write pointer, which then increments.
- Pop: out_pc_valid && out_pc_ready. The read pointer increments.
- Output timing:
  - First-word-fall-through: out_pc and out_cc_id always present the head entry while out_pc_valid = 1.
  - An entry pushed into an empty buffer is visible one cycle later. There is no same-cycle bypass from in_* to out_*.
- Count updates:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop in the same cycle: unchanged, both pointers advance.
- Full: in_pc_ready = 0. A simultaneous pop does not enable a push in that cycle; the push is accepted the next cycle.
- Empty: out_pc_valid = 0. out_pc_ready is ignored.
- Ordering: strict FIFO; entries are never reordered or modified.
- Flush (synchronous):
  - Next state is count = 0 with both pointers at 0.
  - in_pc_ready = 0 during the flush cycle.
  - Any pop offered in that cycle is not counted as a transfer.
- Held offers: in_pc_valid held high with unchanged data across cycles is taken exactly once per handshake. The upstream must drop valid, or change data, after the transfer.
- Pointer wrap: after 2**DEPTH_BITS pushes and pops, the pointers wrap with no loss or duplication.

Optional Feature:
- Macro: REGEX_PC_BUFFER_DEDUP_EN.
- When defined:
  - Each offered {cc_id, pc} is compared combinationally against every occupied entry.
  - On a match the entry is accepted (in_pc_ready still = !full) but not stored; count and pointers are unchanged.
  - A 1-bit output port dup_dropped pulses high for one cycle, registered in the cycle after the dropped push. It resets to 0.
  - A duplicate offered while the buffer is full is not accepted (in_pc_ready = 0).
  - The entry being popped in the same cycle is still counted as occupied for comparison.
- When undefined:
  - No comparators are built.
  - The dup_dropped port does not exist.
  - Every handshake stores an entry.

Test Plan:
- Reset and single entry: hold rst = 0 for 2 cycles, then release. Require count = 0, empty = 1, in_pc_ready = 1. Push (cc 1, pc 0x062) → next cycle out_pc_valid = 1, out_pc = 0x062, out_cc_id = 1, count = 1. Pop → empty = 1.
- Fill and order: push pcs 0x062..0x071 with cc_id = pc[1:0] (16 entries) → full = 1, in_pc_ready = 0, count = 16. Pop all → same order and cc_ids; empty after the 16th pop.
- Full with simultaneous pop/push: at full, assert out_pc_ready and offer pc 0x100 → that cycle only the pop occurs (count 15). Next cycle the push is accepted (count 16). The 0x100 entry emerges last.
- Wrap and concurrency: 40 cycles of simultaneous push and pop with count held at 3 → count stays 3 and the output sequence equals the input sequence across two pointer wraps.
- Flush and mid-operation reset: with 5 entries, pulse flush while pushing 0x0AA → count = 0, 0x0AA is not stored. Refill 3 entries, assert rst asynchronously mid-cycle → out_pc_valid drops before the next edge, count = 0.
- Dedup (macro defined): push (2, 0x0C8), (2, 0x0C8), (3, 0x0C8) → count = 2, dup_dropped pulses once. Output is (2, 0x0C8) then (3, 0x0C8). With the macro undefined, count = 3.

Source files
------------

// File: rtl/regex_pc_buffer.sv
// regex_pc_buffer: first-word-fall-through thread-list FIFO of {cc_id, pc} pairs.
// Written by the output_pc side of regex_cpu and drained by its input_pc side.
// The head entry, count and status flags are registered. A push into an empty
// buffer shows up at the output one cycle later.
// Optional build macro: REGEX_PC_BUFFER_DEDUP_EN. When it is defined, an offered
// entry that matches an occupied entry is accepted but not stored, and the
// dup_dropped output pulses for one cycle.
module regex_pc_buffer #(
    parameter int PC_WIDTH   = 9,
    parameter int CC_ID_BITS = 2,
    parameter int DEPTH_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_pc_valid,
    input  logic [CC_ID_BITS-1:0] in_cc_id,
    input  logic [PC_WIDTH-1:0]   in_pc,
    output logic                  in_pc_ready,
    output logic                  out_pc_valid,
    output logic [CC_ID_BITS-1:0] out_cc_id,
    output logic [PC_WIDTH-1:0]   out_pc,
    input  logic                  out_pc_ready,
    output logic [DEPTH_BITS:0]   count,
    output logic                  empty,
    output logic                  full
`ifdef REGEX_PC_BUFFER_DEDUP_EN
    ,
    output logic                  dup_dropped
`endif
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam int EW    = CC_ID_BITS + PC_WIDTH;

    logic [EW-1:0]         mem_r [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_r;
    logic [DEPTH_BITS-1:0] rd_ptr_r;
    logic [DEPTH_BITS:0]   count_r;
    logic [EW-1:0]         head_r;
    logic                  valid_r;
    logic                  empty_r;
    logic                  full_r;

    logic                  push_s;
    logic                  pop_s;
    logic                  store_s;
    logic [DEPTH_BITS-1:0] wr_ptr_nxt_s;
    logic [DEPTH_BITS-1:0] rd_ptr_nxt_s;
    logic [DEPTH_BITS:0]   count_nxt_s;
    logic [EW-1:0]         head_nxt_s;

    // Ready is withdrawn while full or flushing. A pop in the same cycle does not free a slot.
    assign in_pc_ready = !full_r && !flush;
    assign push_s      = in_pc_valid && in_pc_ready;
    // A pop offered during a flush is not a transfer.
    assign pop_s       = valid_r && out_pc_ready && !flush;

`ifdef REGEX_PC_BUFFER_DEDUP_EN
    logic dup_match_s;
    logic dup_r;

    // Compare the offer against every occupied slot. Occupancy is the distance from rd_ptr below count_r.
    always_comb begin
        dup_match_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            dup_match_s = dup_match_s |
                (({1'b0, DEPTH_BITS'(i) - rd_ptr_r} < count_r) &&
                 (mem_r[i] == {in_cc_id, in_pc}));
        end
    end

    assign store_s     = push_s && !dup_match_s;
    assign dup_dropped = dup_r;

    // Pulse dup_dropped in the cycle after an accepted duplicate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dup_r <= 1'b0;
        end else begin
            dup_r <= push_s && dup_match_s;
        end
    end
`else
    assign store_s = push_s;
`endif

    // Next pointers, count and head entry. Flush overrides push and pop.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        head_nxt_s   = head_r;
        if (flush) begin
            wr_ptr_nxt_s = '0;
            rd_ptr_nxt_s = '0;
            count_nxt_s  = '0;
            head_nxt_s   = '0;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r + DEPTH_BITS'(store_s);
            rd_ptr_nxt_s = rd_ptr_r + DEPTH_BITS'(pop_s);
            case ({store_s, pop_s})
                2'b10:   count_nxt_s = count_r + (DEPTH_BITS+1)'(1);
                2'b01:   count_nxt_s = count_r - (DEPTH_BITS+1)'(1);
                default: count_nxt_s = count_r;
            endcase
            // The new entry becomes the head when it lands on the slot the read pointer moves to.
            if (store_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
                head_nxt_s = {in_cc_id, in_pc};
            end else begin
                head_nxt_s = mem_r[rd_ptr_nxt_s];
            end
        end
    end

    // Control state and registered outputs. Reset discards every entry at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            head_r   <= '0;
            valid_r  <= 1'b0;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            head_r   <= head_nxt_s;
            valid_r  <= (count_nxt_s != (DEPTH_BITS+1)'(0));
            empty_r  <= (count_nxt_s == (DEPTH_BITS+1)'(0));
            full_r   <= (count_nxt_s == (DEPTH_BITS+1)'(DEPTH));
        end
    end

    // Entry storage, which is not reset.
    always_ff @(posedge clk) begin
        if (store_s) begin
            mem_r[wr_ptr_r] <= {in_cc_id, in_pc};
        end
    end

    assign out_pc_valid = valid_r;
    assign out_cc_id    = head_r[EW-1:PC_WIDTH];
    assign out_pc       = head_r[PC_WIDTH-1:0];
    assign count        = count_r;
    assign empty        = empty_r;
    assign full         = full_r;

endmodule

// File: tb/tb_regex_pc_buffer.sv
// Directed bench for regex_pc_buffer. All expected values are worked out by hand
// from the FIFO behaviour.
module tb_regex_pc_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       in_pc_valid = 1'b0;
    logic [1:0] in_cc_id = 2'd0;
    logic [8:0] in_pc = 9'd0;
    logic       in_pc_ready;
    logic       out_pc_valid;
    logic [1:0] out_cc_id;
    logic [8:0] out_pc;
    logic       out_pc_ready = 1'b0;
    logic [4:0] count;
    logic       empty;
    logic       full;
`ifdef REGEX_PC_BUFFER_DEDUP_EN
    logic       dup_dropped;
`endif

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    regex_pc_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_pc_valid (in_pc_valid),
        .in_cc_id    (in_cc_id),
        .in_pc       (in_pc),
        .in_pc_ready (in_pc_ready),
        .out_pc_valid(out_pc_valid),
        .out_cc_id   (out_cc_id),
        .out_pc      (out_pc),
        .out_pc_ready(out_pc_ready),
        .count       (count),
        .empty       (empty),
        .full        (full)
`ifdef REGEX_PC_BUFFER_DEDUP_EN
        ,
        .dup_dropped (dup_dropped)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        compared++;
        if (out_pc_valid !== 1'b0 || out_pc !== 9'd0 || out_cc_id !== 2'd0) begin
            mismatched++;
            $display("FAIL reset_out: valid=%0b pc=%h cc=%0d want 0/000/0", out_pc_valid, out_pc, out_cc_id);
        end
        rst = 1'b1;
        #1;
        compared++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || in_pc_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_flags: count=%0d empty=%0b full=%0b ready=%0b want 0/1/0/1",
                     count, empty, full, in_pc_ready);
        end
    endtask

    task automatic test_single();
        in_pc_valid = 1'b1;
        in_cc_id    = 2'd1;
        in_pc       = 9'h062;
        #1;
        compared++;
        if (out_pc_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL no_bypass: out_pc_valid=%0b want 0", out_pc_valid);
        end
        tick();
        in_pc_valid = 1'b0;
        compared++;
        if (out_pc_valid !== 1'b1 || out_pc !== 9'h062 || out_cc_id !== 2'd1 || count !== 5'd1) begin
            mismatched++;
            $display("FAIL single_push: valid=%0b pc=%h cc=%0d count=%0d want 1/062/1/1",
                     out_pc_valid, out_pc, out_cc_id, count);
        end
        out_pc_ready = 1'b1;
        tick();
        out_pc_ready = 1'b0;
        compared++;
        if (empty !== 1'b1 || out_pc_valid !== 1'b0 || count !== 5'd0) begin
            mismatched++;
            $display("FAIL single_pop: empty=%0b valid=%0b count=%0d want 1/0/0", empty, out_pc_valid, count);
        end
    endtask

    task automatic test_fill_and_full();
        logic [8:0] p;
        for (int i = 0; i < 16; i++) begin
            p = 9'h062 + 9'(i);
            in_pc_valid = 1'b1;
            in_pc       = p;
            in_cc_id    = p[1:0];
            tick();
        end
        in_pc_valid = 1'b0;
        compared++;
        if (full !== 1'b1 || in_pc_ready !== 1'b0 || count !== 5'd16) begin
            mismatched++;
            $display("FAIL fill_full: full=%0b ready=%0b count=%0d want 1/0/16", full, in_pc_ready, count);
        end
        compared++;
        if (out_pc !== 9'h062 || out_cc_id !== 2'd2) begin
            mismatched++;
            $display("FAIL fill_head: pc=%h cc=%0d want 062/2", out_pc, out_cc_id);
        end
        // Pop and push offered together while full: only the pop happens.
        out_pc_ready = 1'b1;
        in_pc_valid  = 1'b1;
        in_pc        = 9'h100;
        in_cc_id     = 2'd2;
        tick();
        out_pc_ready = 1'b0;
        compared++;
        if (count !== 5'd15 || in_pc_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL full_pop_only: count=%0d ready=%0b want 15/1", count, in_pc_ready);
        end
        tick();
        in_pc_valid = 1'b0;
        compared++;
        if (count !== 5'd16 || full !== 1'b1) begin
            mismatched++;
            $display("FAIL full_push_next: count=%0d full=%0b want 16/1", count, full);
        end
        // Drain: 0x063..0x071 in order, then 0x100 last.
        out_pc_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i < 15) p = 9'h063 + 9'(i);
            else        p = 9'h100;
            compared++;
            if (out_pc_valid !== 1'b1 || out_pc !== p || out_cc_id !== ((i < 15) ? p[1:0] : 2'd2)) begin
                mismatched++;
                $display("FAIL drain_order[%0d]: valid=%0b pc=%h cc=%0d want pc %h", i, out_pc_valid, out_pc, out_cc_id, p);
            end
            tick();
        end
        out_pc_ready = 1'b0;
        compared++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            mismatched++;
            $display("FAIL drain_empty: empty=%0b count=%0d want 1/0", empty, count);
        end
    endtask

    task automatic test_wrap();
        logic [8:0] p;
        for (int i = 0; i < 3; i++) begin
            p = 9'h1A0 + 9'(i);
            in_pc_valid = 1'b1;
            in_pc       = p;
            in_cc_id    = p[1:0];
            tick();
        end
        out_pc_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            p        = 9'h1A0 + 9'(c + 3);
            in_pc    = p;
            in_cc_id = p[1:0];
            p        = 9'h1A0 + 9'(c);
            compared++;
            if (count !== 5'd3 || out_pc !== p || out_cc_id !== p[1:0]) begin
                mismatched++;
                $display("FAIL wrap[%0d]: count=%0d pc=%h cc=%0d want 3/%h/%0d", c, count, out_pc, out_cc_id, p, p[1:0]);
            end
            tick();
        end
        in_pc_valid = 1'b0;
        for (int c = 40; c < 43; c++) begin
            p = 9'h1A0 + 9'(c);
            compared++;
            if (out_pc_valid !== 1'b1 || out_pc !== p) begin
                mismatched++;
                $display("FAIL wrap_tail[%0d]: valid=%0b pc=%h want 1/%h", c, out_pc_valid, out_pc, p);
            end
            tick();
        end
        out_pc_ready = 1'b0;
        compared++;
        if (empty !== 1'b1) begin
            mismatched++;
            $display("FAIL wrap_empty: empty=%0b want 1", empty);
        end
    endtask

    task automatic test_flush_and_reset();
        for (int i = 0; i < 5; i++) begin
            in_pc_valid = 1'b1;
            in_pc       = 9'h0A0 + 9'(i);
            in_cc_id    = 2'd0;
            tick();
        end
        flush        = 1'b1;
        in_pc        = 9'h0AA;
        out_pc_ready = 1'b1;
        #1;
        compared++;
        if (in_pc_ready !== 1'b0 || count !== 5'd5) begin
            mismatched++;
            $display("FAIL flush_ready: ready=%0b count=%0d want 0/5", in_pc_ready, count);
        end
        @(posedge clk);
        #1;
        flush        = 1'b0;
        in_pc_valid  = 1'b0;
        out_pc_ready = 1'b0;
        compared++;
        if (count !== 5'd0 || empty !== 1'b1 || out_pc_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL flush_clear: count=%0d empty=%0b valid=%0b want 0/1/0", count, empty, out_pc_valid);
        end
        tick();
        compared++;
        if (count !== 5'd0) begin
            mismatched++;
            $display("FAIL flush_nostore: count=%0d want 0", count);
        end
        for (int i = 0; i < 3; i++) begin
            in_pc_valid = 1'b1;
            in_pc       = 9'h0B0 + 9'(i);
            tick();
        end
        in_pc_valid = 1'b0;
        compared++;
        if (count !== 5'd3 || out_pc !== 9'h0B0) begin
            mismatched++;
            $display("FAIL refill: count=%0d pc=%h want 3/0b0", count, out_pc);
        end
        #2;
        rst = 1'b0;
        #1;
        compared++;
        if (out_pc_valid !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin
            mismatched++;
            $display("FAIL async_reset: valid=%0b count=%0d empty=%0b want 0/0/1", out_pc_valid, count, empty);
        end
        tick();
        rst = 1'b1;
        tick();
        compared++;
        if (out_pc_valid !== 1'b0 || count !== 5'd0 || in_pc_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL after_reset: valid=%0b count=%0d ready=%0b want 0/0/1", out_pc_valid, count, in_pc_ready);
        end
    endtask

    task automatic test_dedup();
        logic [10:0] offers [3];
        logic [10:0] expect_q [$];
        int          pulses;
        logic [4:0]  exp_count;
        offers[0] = {2'd2, 9'h0C8};
        offers[1] = {2'd2, 9'h0C8};
        offers[2] = {2'd3, 9'h0C8};
        pulses = 0;
`ifdef REGEX_PC_BUFFER_DEDUP_EN
        exp_count = 5'd2;
        expect_q.push_back(offers[0]);
        expect_q.push_back(offers[2]);
`else
        exp_count = 5'd3;
        expect_q.push_back(offers[0]);
        expect_q.push_back(offers[1]);
        expect_q.push_back(offers[2]);
`endif
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                in_pc_valid = 1'b1;
                {in_cc_id, in_pc} = offers[i];
            end else begin
                in_pc_valid = 1'b0;
            end
            tick();
`ifdef REGEX_PC_BUFFER_DEDUP_EN
            if (dup_dropped === 1'b1) pulses++;
            compared++;
            if (dup_dropped !== ((i == 1) ? 1'b1 : 1'b0)) begin
                mismatched++;
                $display("FAIL dup_pulse[%0d]: dup_dropped=%0b want %0b", i, dup_dropped, (i == 1));
            end
`endif
        end
        compared++;
        if (count !== exp_count) begin
            mismatched++;
            $display("FAIL dedup_count: count=%0d want %0d", count, exp_count);
        end
`ifdef REGEX_PC_BUFFER_DEDUP_EN
        compared++;
        if (pulses != 1) begin
            mismatched++;
            $display("FAIL dup_pulses: got %0d want 1", pulses);
        end
`endif
        out_pc_ready = 1'b1;
        foreach (expect_q[k]) begin
            compared++;
            if (out_pc_valid !== 1'b1 || {out_cc_id, out_pc} !== expect_q[k]) begin
                mismatched++;
                $display("FAIL dedup_order[%0d]: valid=%0b got %h want %h", k, out_pc_valid, {out_cc_id, out_pc}, expect_q[k]);
            end
            tick();
        end
        out_pc_ready = 1'b0;
        compared++;
        if (empty !== 1'b1) begin
            mismatched++;
            $display("FAIL dedup_empty: empty=%0b want 1", empty);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_and_full();
        test_wrap();
        test_flush_and_reset();
        test_dedup();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
